// File: rtl/bmp280_compensate.sv
// BMP280 temperature/pressure compensation engine.
// Converts raw 20-bit ADC codes plus factory trim coefficients into a
// temperature in 0.01 degC, a pressure in Pa and the t_fine intermediate.
// The arithmetic follows the Bosch int32 reference bit for bit.
//
// Ports
//   clk             system clock
//   rst_n           synchronous active-low reset
//   dat_valid       level from the sensor driver; a rising edge seen in IDLE
//                   starts a computation
//   dig_t1..dig_t3  temperature trim (t1 unsigned, t2/t3 signed)
//   dig_p1..dig_p9  pressure trim (p1 unsigned, p2..p9 signed)
//   adc_t, adc_p    raw unsigned ADC codes
//   busy            high while a computation is in flight
//   out_valid       one-cycle pulse when temp/press/t_fine update
//   temp            signed temperature, 0.01 degC
//   press           unsigned pressure, Pa
//   t_fine          signed fine temperature (debug)
//
// state   | meaning
// IDLE    | waiting for a dat_valid rising edge; inputs captured on start
// TEMP    | temperature compensation, t_fine and temp computed
// PRESS_A | pressure numerator n and divisor a computed
// DIV     | 32-cycle restoring divide, one quotient bit per cycle
// PRESS_B | final pressure correction
// DONE    | publish results, pulse out_valid

module bmp280_compensate (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dat_valid,
  input  logic [15:0] dig_t1,
  input  logic [15:0] dig_t2,
  input  logic [15:0] dig_t3,
  input  logic [15:0] dig_p1,
  input  logic [15:0] dig_p2,
  input  logic [15:0] dig_p3,
  input  logic [15:0] dig_p4,
  input  logic [15:0] dig_p5,
  input  logic [15:0] dig_p6,
  input  logic [15:0] dig_p7,
  input  logic [15:0] dig_p8,
  input  logic [15:0] dig_p9,
  input  logic [19:0] adc_t,
  input  logic [19:0] adc_p,
  output logic        busy,
  output logic        out_valid,
  output logic [15:0] temp,
  output logic [19:0] press,
  output logic [31:0] t_fine
);

  typedef enum logic [2:0] {IDLE, TEMP, PRESS_A, DIV, PRESS_B, DONE} state_t;

  state_t state;

  logic        dv_q;
  logic        dv_seen;
  logic [15:0] t1_r, t2_r, t3_r;
  logic [15:0] p1_r, p2_r, p3_r, p4_r, p5_r, p6_r, p7_r, p8_r, p9_r;
  logic [19:0] adc_t_r, adc_p_r;

  logic signed [31:0] t_fine_r;
  logic [15:0]        temp_r;
  logic [19:0]        press_r;

  logic [31:0] den_r, dvd_r, rem_r, q_r;
  logic        n_big_r;
  logic [4:0]  div_cnt;

  function automatic logic signed [31:0] sx16(input logic [15:0] v);
    return $signed({{16{v[15]}}, v});
  endfunction

  // dv_seen keeps the first post-reset sample from looking like an edge,
  // so a dat_valid already high at reset release does not start anything.
  logic start;
  assign start = dat_valid & ~dv_q & dv_seen;

  // temperature stage
  logic signed [31:0] t_adc, t_t1, t_v1, t_d, t_v2, t_fine_c;
  always_comb begin
    t_adc    = $signed({12'd0, adc_t_r});
    t_t1     = $signed({16'd0, t1_r});
    t_v1     = (((t_adc >>> 3) - (t_t1 <<< 1)) * sx16(t2_r)) >>> 11;
    t_d      = (t_adc >>> 4) - t_t1;
    t_v2     = (((t_d * t_d) >>> 12) * sx16(t3_r)) >>> 14;
    t_fine_c = t_v1 + t_v2;
  end

  // pressure stage A: divisor a (pa_a3) and numerator n (pa_n)
  logic signed [31:0] pa_a, pa_h, pa_s, pa_b1, pa_b2, pa_a2, pa_a3;
  logic [31:0]        pa_n;
  always_comb begin
    pa_a  = (t_fine_r >>> 1) - 32'sd64000;
    pa_h  = pa_a >>> 2;
    pa_s  = pa_h * pa_h;
    pa_b1 = ((pa_s >>> 11) * sx16(p6_r)) + ((pa_a * sx16(p5_r)) <<< 1);
    pa_b2 = (pa_b1 >>> 2) + (sx16(p4_r) <<< 16);
    pa_a2 = (((sx16(p3_r) * (pa_s >>> 13)) >>> 3) + ((sx16(p2_r) * pa_a) >>> 1)) >>> 18;
    pa_a3 = ((32'sd32768 + pa_a2) * $signed({16'd0, p1_r})) >>> 15;
    pa_n  = $unsigned(((32'sd1048576 - $signed({12'd0, adc_p_r})) - (pa_b2 >>> 12)) * 32'sd3125);
  end

  // divider step and final-quotient scaling
  logic [32:0] rem_sh;
  logic [32:0] den_ext;
  logic        div_ge;
  logic [31:0] rem_nx;
  logic [31:0] p_val;
  always_comb begin
    rem_sh  = {rem_r, dvd_r[31]};
    den_ext = {1'b0, den_r};
    div_ge  = (rem_sh >= den_ext);
    rem_nx  = div_ge ? 32'(rem_sh - den_ext) : rem_sh[31:0];
    // large numerators are divided unshifted and the quotient doubled
    p_val   = n_big_r ? {q_r[30:0], 1'b0} : q_r;
  end

  // pressure stage B
  logic [31:0]        pb_q, pb_sq;
  logic signed [31:0] pb_c, pb_e;
  always_comb begin
    pb_q  = p_val >> 3;
    pb_sq = (pb_q * pb_q) >> 13;
    pb_c  = (sx16(p9_r) * $signed(pb_sq)) >>> 12;
    pb_e  = ($signed(p_val >> 2) * sx16(p8_r)) >>> 13;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      temp      <= '0;
      press     <= '0;
      t_fine    <= '0;
      dv_q      <= 1'b0;
      dv_seen   <= 1'b0;
      t1_r <= '0; t2_r <= '0; t3_r <= '0;
      p1_r <= '0; p2_r <= '0; p3_r <= '0; p4_r <= '0; p5_r <= '0;
      p6_r <= '0; p7_r <= '0; p8_r <= '0; p9_r <= '0;
      adc_t_r   <= '0;
      adc_p_r   <= '0;
      t_fine_r  <= '0;
      temp_r    <= '0;
      press_r   <= '0;
      den_r     <= '0;
      dvd_r     <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      n_big_r   <= 1'b0;
      div_cnt   <= '0;
    end else begin
      dv_q      <= dat_valid;
      dv_seen   <= 1'b1;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            t1_r <= dig_t1; t2_r <= dig_t2; t3_r <= dig_t3;
            p1_r <= dig_p1; p2_r <= dig_p2; p3_r <= dig_p3; p4_r <= dig_p4;
            p5_r <= dig_p5; p6_r <= dig_p6; p7_r <= dig_p7; p8_r <= dig_p8;
            p9_r <= dig_p9;
            adc_t_r <= adc_t;
            adc_p_r <= adc_p;
            busy    <= 1'b1;
            state   <= TEMP;
          end
        end
        TEMP: begin
          t_fine_r <= t_fine_c;
          temp_r   <= 16'((t_fine_c * 32'sd5 + 32'sd128) >>> 8);
          state    <= PRESS_A;
        end
        PRESS_A: begin
          den_r   <= pa_a3;
          n_big_r <= pa_n[31];
          dvd_r   <= pa_n[31] ? pa_n : {pa_n[30:0], 1'b0};
          rem_r   <= '0;
          q_r     <= '0;
          div_cnt <= 5'd31;
          if (pa_a3 == 32'sd0) begin
            press_r <= '0;
            state   <= DONE;
          end else begin
            state   <= DIV;
          end
        end
        DIV: begin
          rem_r <= rem_nx;
          dvd_r <= {dvd_r[30:0], 1'b0};
          q_r   <= {q_r[30:0], div_ge};
          if (div_cnt == 5'd0) state <= PRESS_B;
          else div_cnt <= div_cnt - 5'd1;
        end
        PRESS_B: begin
          press_r <= 20'(p_val + $unsigned((pb_c + pb_e + sx16(p7_r)) >>> 4));
          state   <= DONE;
        end
        DONE: begin
          temp      <= temp_r;
          press     <= press_r;
          t_fine    <= t_fine_r;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp280_compensate.sv
// Directed bench for bmp280_compensate: datasheet vector, zero divisor,
// retrigger, mid-operation reset, input isolation and a seeded random sweep
// against an int32 reference model.
module tb_bmp280_compensate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dat_valid;
  logic [15:0] dig_t1, dig_t2, dig_t3;
  logic [15:0] dig_p1, dig_p2, dig_p3, dig_p4, dig_p5, dig_p6, dig_p7, dig_p8, dig_p9;
  logic [19:0] adc_t, adc_p;
  logic        busy, out_valid;
  logic [15:0] temp;
  logic [19:0] press;
  logic [31:0] t_fine;

  int vectors = 0;
  int errs = 0;

  bmp280_compensate dut (
    .clk(clk), .rst_n(rst_n), .dat_valid(dat_valid),
    .dig_t1(dig_t1), .dig_t2(dig_t2), .dig_t3(dig_t3),
    .dig_p1(dig_p1), .dig_p2(dig_p2), .dig_p3(dig_p3), .dig_p4(dig_p4),
    .dig_p5(dig_p5), .dig_p6(dig_p6), .dig_p7(dig_p7), .dig_p8(dig_p8),
    .dig_p9(dig_p9), .adc_t(adc_t), .adc_p(adc_p),
    .busy(busy), .out_valid(out_valid), .temp(temp), .press(press), .t_fine(t_fine)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic set_ds();
    dig_t1 = 16'd27504; dig_t2 = 16'd26435; dig_t3 = -16'sd1000;
    dig_p1 = 16'd36477; dig_p2 = -16'sd10685; dig_p3 = 16'd3024;
    dig_p4 = 16'd2855;  dig_p5 = 16'd140;     dig_p6 = -16'sd7;
    dig_p7 = 16'd15500; dig_p8 = -16'sd14600; dig_p9 = 16'd6000;
    adc_t  = 20'd519888; adc_p = 20'd415148;
  endtask

  task automatic rand_inputs();
    dig_t1 = 16'($urandom); dig_t2 = 16'($urandom); dig_t3 = 16'($urandom);
    dig_p1 = 16'($urandom); dig_p2 = 16'($urandom); dig_p3 = 16'($urandom);
    dig_p4 = 16'($urandom); dig_p5 = 16'($urandom); dig_p6 = 16'($urandom);
    dig_p7 = 16'($urandom); dig_p8 = 16'($urandom); dig_p9 = 16'($urandom);
    adc_t  = 20'($urandom); adc_p  = 20'($urandom);
  endtask

  // Bosch int32/uint32 reference compensation
  function automatic void golden(output int tf, output int tp, output int unsigned pr);
    int adt, adp, t1, v1, v2, d, a, s, b, a2, a3, c, e;
    int unsigned n, p, sq;
    adt = int'({12'd0, adc_t});
    adp = int'({12'd0, adc_p});
    t1  = int'({16'd0, dig_t1});
    v1  = (((adt >>> 3) - (t1 << 1)) * int'($signed(dig_t2))) >>> 11;
    d   = (adt >>> 4) - t1;
    v2  = (((d * d) >>> 12) * int'($signed(dig_t3))) >>> 14;
    tf  = v1 + v2;
    tp  = (tf * 5 + 128) >>> 8;
    a   = (tf >>> 1) - 64000;
    s   = (a >>> 2) * (a >>> 2);
    b   = ((s >>> 11) * int'($signed(dig_p6))) + ((a * int'($signed(dig_p5))) << 1);
    b   = (b >>> 2) + (int'($signed(dig_p4)) << 16);
    a2  = (((int'($signed(dig_p3)) * (s >>> 13)) >>> 3) + ((int'($signed(dig_p2)) * a) >>> 1)) >>> 18;
    a3  = ((32768 + a2) * int'({16'd0, dig_p1})) >>> 15;
    if (a3 == 0) begin
      pr = 0;
      return;
    end
    n = ((1048576 - adp) - (b >>> 12)) * 3125;
    if (n < 32'h80000000) p = (n << 1) / a3;
    else p = (n / a3) << 1;
    sq = ((p >> 3) * (p >> 3)) >> 13;
    c  = (int'($signed(dig_p9)) * int'(sq)) >>> 12;
    e  = (int'(p >> 2) * int'($signed(dig_p8))) >>> 13;
    pr = (p + ((c + e + int'($signed(dig_p7))) >>> 4)) & 32'h000FFFFF;
  endfunction

  // Raise dat_valid, watch a window of cycles, then drop it again.
  task automatic run_calc(input int win, input bit early, input bit scramble,
                          output int first, output int pulses,
                          output logic busy_mid, output logic [19:0] press_mid);
    first = -1; pulses = 0; busy_mid = 1'b0; press_mid = '0;
    dat_valid = 1'b1;
    for (int i = 1; i <= win; i++) begin
      tick();
      if (i == 1 && scramble) rand_inputs();
      if (i == 3) begin busy_mid = busy; press_mid = press; end
      if (out_valid) begin
        pulses++;
        if (first < 0) first = i - 1;
        if (early) break;
      end
    end
    dat_valid = 1'b0;
    tick();
  endtask

  initial begin
    int first, pulses, lat_ref, tf, tp;
    int unsigned pr;
    logic bm;
    logic [19:0] pm;
    logic [15:0] exp_t;

    rst_n = 1'b0; dat_valid = 1'b0;
    set_ds();
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_temp", {16'd0, temp}, 32'd0);
    chk("rst_press", {12'd0, press}, 32'd0);
    chk("rst_t_fine", t_fine, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // datasheet vector
    run_calc(90, 1'b0, 1'b0, first, pulses, bm, pm);
    lat_ref = first;
    chk("ds_pulses", pulses, 32'd1);
    chk("ds_latency_le64", {31'd0, (first >= 0 && first <= 64)}, 32'd1);
    chk("ds_busy_mid", {31'd0, bm}, 32'd1);
    chk("ds_t_fine", t_fine, 32'd128422);
    chk("ds_temp", {16'd0, temp}, 32'd2508);
    chk("ds_press", {12'd0, press}, 32'd100656);
    chk("ds_idle_busy", {31'd0, busy}, 32'd0);

    // zero divisor
    dig_p1 = 16'd0;
    run_calc(90, 1'b0, 1'b0, first, pulses, bm, pm);
    chk("zd_press_held", {12'd0, pm}, 32'd100656);
    chk("zd_pulses", pulses, 32'd1);
    chk("zd_latency_le64", {31'd0, (first >= 0 && first <= 64)}, 32'd1);
    chk("zd_press", {12'd0, press}, 32'd0);
    chk("zd_temp", {16'd0, temp}, 32'd2508);
    chk("zd_t_fine", t_fine, 32'd128422);
    set_ds();

    // second edge while busy, then dat_valid held high
    first = -1; pulses = 0;
    dat_valid = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      tick();
      if (i == 9) dat_valid = 1'b0;
      if (i == 10) dat_valid = 1'b1;
      if (out_valid) begin
        pulses++;
        if (first < 0) first = i - 1;
      end
    end
    chk("rt_pulses", pulses, 32'd1);
    chk("rt_latency_const", first, lat_ref);
    chk("rt_press", {12'd0, press}, 32'd100656);
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("hold_high_pulses", pulses, 32'd0);
    chk("hold_high_busy", {31'd0, busy}, 32'd0);
    dat_valid = 1'b0;
    tick();

    // reset in the middle of a computation
    pulses = 0;
    dat_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    rst_n = 1'b0;
    tick();
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_temp", {16'd0, temp}, 32'd0);
    chk("mr_press", {12'd0, press}, 32'd0);
    chk("mr_t_fine", t_fine, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("mr_no_pulse", pulses, 32'd0);
    chk("mr_high_at_release_idle", {31'd0, busy}, 32'd0);
    dat_valid = 1'b0;
    tick();
    run_calc(90, 1'b0, 1'b0, first, pulses, bm, pm);
    chk("mr_after_pulses", pulses, 32'd1);
    chk("mr_after_temp", {16'd0, temp}, 32'd2508);
    chk("mr_after_press", {12'd0, press}, 32'd100656);

    // inputs scrambled right after the capture cycle
    set_ds();
    run_calc(90, 1'b0, 1'b1, first, pulses, bm, pm);
    chk("iso_pulses", pulses, 32'd1);
    chk("iso_t_fine", t_fine, 32'd128422);
    chk("iso_temp", {16'd0, temp}, 32'd2508);
    chk("iso_press", {12'd0, press}, 32'd100656);

    // random sweep against the reference model
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      if (k % 50 == 7) dig_p1 = 16'd0;
      golden(tf, tp, pr);
      exp_t = tp[15:0];
      run_calc(70, 1'b1, 1'b0, first, pulses, bm, pm);
      chk("sw_pulse", pulses, 32'd1);
      chk("sw_t_fine", t_fine, tf);
      chk("sw_temp", {16'd0, temp}, {16'd0, exp_t});
      chk("sw_press", {12'd0, press}, pr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
